// File: rtl/bcd_seg_scan_display_pkg.sv
// Shared types and glyph constants for the multiplexed 3-digit 7-segment display.
// Glyphs are active-high with bit 0 = segment a through bit 6 = segment g.
package seg_disp_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic {ST_BLANK, ST_SCAN} state_t;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_frame_t;

endpackage

// File: rtl/bcd_seg_scan_display_if.sv
// Display bus: counter-side inputs into the scanner and the physical display outputs.
// The master drives digits/controls; the slave (scanner) drives segments, anodes and status.
interface bcd_seg_scan_display_if;
  logic       enable;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] hundreds;
  logic       ovf_in;
  logic       ovf_clr;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] an;
  logic       frame_strobe;
  logic       ovf_flag;

  modport master (
    output enable, ones, tens, hundreds, ovf_in, ovf_clr,
    input  seg, dp, an, frame_strobe, ovf_flag
  );

  modport slave (
    input  enable, ones, tens, hundreds, ovf_in, ovf_clr,
    output seg, dp, an, frame_strobe, ovf_flag
  );
endinterface

// File: rtl/bcd_seg_scan_display_bcd_to_7seg.sv
// Combinational BCD to active-high 7-segment glyph; non-decimal codes show a dash.
module bcd_to_7seg
  import seg_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_DASH;
    case (bcd)
      4'd0: glyph = GLYPH_0;
      4'd1: glyph = GLYPH_1;
      4'd2: glyph = GLYPH_2;
      4'd3: glyph = GLYPH_3;
      4'd4: glyph = GLYPH_4;
      4'd5: glyph = GLYPH_5;
      4'd6: glyph = GLYPH_6;
      4'd7: glyph = GLYPH_7;
      4'd8: glyph = GLYPH_8;
      4'd9: glyph = GLYPH_9;
      default: glyph = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan_display.sv
// Frame-coherent 3-digit multiplexed 7-segment scanner with sticky overflow on the hundreds dp.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on the hundreds and tens slots.
module bcd_seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic clk,
  input logic reset,
  bcd_seg_scan_display_if.slave bus
);

  localparam int              CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic            POL       = (SEG_ACTIVE_LOW != 0);

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  state_t           state, next_state;
  digit_idx_t       scan_idx, next_idx;
  bcd_frame_t       snapshot, next_snap;
  logic             next_strobe;
  logic             flag, next_flag;
  logic [3:0]       cur_digit;
  logic [6:0]       glyph, glyph_vis;
  logic [6:0]       seg_ah;
  logic [2:0]       an_ah;
  logic             dp_ah;
  logic [6:0]       seg_q;
  logic [2:0]       an_q;
  logic             dp_q;
  logic             strobe_q;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // Everything shown on the display is derived from the post-update scan state,
  // so the slot change and its new pattern land on the same edge.
  always_comb begin
    next_state  = state;
    next_idx    = scan_idx;
    next_snap   = snapshot;
    next_strobe = 1'b0;
    if (tick) begin
      case (state)
        ST_BLANK: begin
          next_state  = ST_SCAN;
          next_idx    = 2'd0;
          next_snap   = '{hundreds: bus.hundreds, tens: bus.tens, ones: bus.ones};
          next_strobe = 1'b1;
        end
        default: begin
          if (scan_idx == 2'd2) begin
            next_idx    = 2'd0;
            next_snap   = '{hundreds: bus.hundreds, tens: bus.tens, ones: bus.ones};
            next_strobe = 1'b1;
          end else begin
            next_idx = scan_idx + 2'd1;
          end
        end
      endcase
    end
    next_flag = bus.ovf_in ? 1'b1 : (bus.ovf_clr ? 1'b0 : flag);
  end

  always_comb begin
    case (next_idx)
      2'd0:    cur_digit = next_snap.ones;
      2'd1:    cur_digit = next_snap.tens;
      default: cur_digit = next_snap.hundreds;
    endcase
  end

  bcd_to_7seg u_dec (
    .bcd   (cur_digit),
    .glyph (glyph)
  );

  always_comb begin
    glyph_vis = glyph;
`ifdef LEADING_ZERO_BLANK_EN
    if (next_idx == 2'd2 && next_snap.hundreds == 4'd0)
      glyph_vis = GLYPH_BLANK;
    else if (next_idx == 2'd1 && next_snap.hundreds == 4'd0 && next_snap.tens == 4'd0)
      glyph_vis = GLYPH_BLANK;
`endif
    seg_ah = GLYPH_BLANK;
    an_ah  = 3'b000;
    dp_ah  = 1'b0;
    if (next_state == ST_SCAN) begin
      seg_ah = glyph_vis;
      if (bus.enable) begin
        case (next_idx)
          2'd0:    an_ah = 3'b001;
          2'd1:    an_ah = 3'b010;
          default: an_ah = 3'b100;
        endcase
        dp_ah = (next_idx == 2'd2) && next_flag;
      end
    end
  end

  // Polarity is applied only here so all internal logic stays active-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_BLANK;
      scan_idx <= 2'd0;
      snapshot <= '0;
      flag     <= 1'b0;
      strobe_q <= 1'b0;
      seg_q    <= {7{POL}};
      an_q     <= {3{POL}};
      dp_q     <= POL;
    end else begin
      state    <= next_state;
      scan_idx <= next_idx;
      snapshot <= next_snap;
      flag     <= next_flag;
      strobe_q <= next_strobe;
      seg_q    <= seg_ah ^ {7{POL}};
      an_q     <= an_ah ^ {3{POL}};
      dp_q     <= dp_ah ^ POL;
    end
  end

  assign bus.seg          = seg_q;
  assign bus.an           = an_q;
  assign bus.dp           = dp_q;
  assign bus.frame_strobe = strobe_q;
  assign bus.ovf_flag     = flag;

endmodule

// File: tb/tb_bcd_seg_scan_display.sv
// Directed self-checking bench for bcd_seg_scan_display at REFRESH_DIV=4, active-low outputs.
// Edge numbers below count rising edges after reset release; each slot lasts 4 edges.
module tb_bcd_seg_scan_display;
  import seg_disp_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  bcd_seg_scan_display_if bus ();

  bcd_seg_scan_display #(
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    bus.hundreds = h;
    bus.tens     = t;
    bus.ones     = o;
  endtask

  // Advance n rising edges and park on the following falling edge for sampling.
  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Expected values are given active-high; the outputs are active-low.
  task automatic checkOutput(input string tag, input logic [6:0] exp_glyph,
                             input logic [2:0] exp_an, input logic exp_dp,
                             input logic exp_strobe, input logic exp_flag);
    logic [6:0] es;
    logic [2:0] ea;
    logic       ed;
    es = ~exp_glyph;
    ea = ~exp_an;
    ed = ~exp_dp;
    vectors++;
    assert (bus.seg === es) else begin
      miscompares++;
      $error("[TB] FAIL %s seg observed=%b expected=%b", tag, bus.seg, es);
    end
    vectors++;
    assert (bus.an === ea) else begin
      miscompares++;
      $error("[TB] FAIL %s an observed=%b expected=%b", tag, bus.an, ea);
    end
    vectors++;
    assert (bus.dp === ed) else begin
      miscompares++;
      $error("[TB] FAIL %s dp observed=%b expected=%b", tag, bus.dp, ed);
    end
    vectors++;
    assert (bus.frame_strobe === exp_strobe) else begin
      miscompares++;
      $error("[TB] FAIL %s frame_strobe observed=%b expected=%b", tag, bus.frame_strobe, exp_strobe);
    end
    vectors++;
    assert (bus.ovf_flag === exp_flag) else begin
      miscompares++;
      $error("[TB] FAIL %s ovf_flag observed=%b expected=%b", tag, bus.ovf_flag, exp_flag);
    end
  endtask

  initial begin
    logic [6:0] lz_glyph;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.enable  = 1'b1;
    bus.ovf_in  = 1'b0;
    bus.ovf_clr = 1'b0;
    applyStimulus(4'd1, 4'd2, 4'd3);

    @(negedge clk);
    checkOutput("in_reset", GLYPH_BLANK, 3'b000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    waitEdges(1);
    checkOutput("blank_e1", GLYPH_BLANK, 3'b000, 1'b0, 1'b0, 1'b0);
    waitEdges(1);
    checkOutput("blank_e2", GLYPH_BLANK, 3'b000, 1'b0, 1'b0, 1'b0);
    waitEdges(1);
    checkOutput("blank_e3", GLYPH_BLANK, 3'b000, 1'b0, 1'b0, 1'b0);

    waitEdges(1);  // E4: first frame
    checkOutput("f1_ones", GLYPH_3, 3'b001, 1'b0, 1'b1, 1'b0);
    waitEdges(1);  // E5
    checkOutput("f1_ones_hold", GLYPH_3, 3'b001, 1'b0, 1'b0, 1'b0);
    waitEdges(3);  // E8
    checkOutput("f1_tens", GLYPH_2, 3'b010, 1'b0, 1'b0, 1'b0);
    waitEdges(1);  // E9: mid-tens input change
    applyStimulus(4'd1, 4'd2, 4'd4);
    waitEdges(3);  // E12
    checkOutput("f1_hundreds", GLYPH_1, 3'b100, 1'b0, 1'b0, 1'b0);
    waitEdges(4);  // E16
    checkOutput("f2_ones_new", GLYPH_4, 3'b001, 1'b0, 1'b1, 1'b0);

    applyStimulus(4'd1, 4'd2, 4'hC);
    waitEdges(4);  // E20
    checkOutput("f2_tens", GLYPH_2, 3'b010, 1'b0, 1'b0, 1'b0);
    waitEdges(8);  // E28
    checkOutput("f3_ones_dash", GLYPH_DASH, 3'b001, 1'b0, 1'b1, 1'b0);

    bus.ovf_in = 1'b1;
    waitEdges(1);  // E29
    bus.ovf_in = 1'b0;
    checkOutput("ovf_set_ones", GLYPH_DASH, 3'b001, 1'b0, 1'b0, 1'b1);
    waitEdges(7);  // E36
    checkOutput("ovf_dp_hundreds", GLYPH_1, 3'b100, 1'b1, 1'b0, 1'b1);

    bus.ovf_in  = 1'b1;
    bus.ovf_clr = 1'b1;
    waitEdges(1);  // E37
    bus.ovf_in  = 1'b0;
    checkOutput("ovf_set_wins", GLYPH_1, 3'b100, 1'b1, 1'b0, 1'b1);
    waitEdges(1);  // E38
    bus.ovf_clr = 1'b0;
    checkOutput("ovf_cleared", GLYPH_1, 3'b100, 1'b0, 1'b0, 1'b0);

    bus.enable = 1'b0;
    waitEdges(1);  // E39
    checkOutput("disabled", GLYPH_1, 3'b000, 1'b0, 1'b0, 1'b0);
    waitEdges(1);  // E40: scan still advanced to a new frame
    checkOutput("disabled_scan", GLYPH_DASH, 3'b000, 1'b0, 1'b1, 1'b0);
    bus.enable = 1'b1;
    waitEdges(1);  // E41
    checkOutput("reenabled", GLYPH_DASH, 3'b001, 1'b0, 1'b0, 1'b0);

    applyStimulus(4'd0, 4'd0, 4'd7);
`ifdef LEADING_ZERO_BLANK_EN
    lz_glyph = GLYPH_BLANK;
`else
    lz_glyph = GLYPH_0;
`endif
    waitEdges(11); // E52
    checkOutput("lz_ones", GLYPH_7, 3'b001, 1'b0, 1'b1, 1'b0);
    waitEdges(4);  // E56
    checkOutput("lz_tens", lz_glyph, 3'b010, 1'b0, 1'b0, 1'b0);
    waitEdges(4);  // E60
    checkOutput("lz_hundreds", lz_glyph, 3'b100, 1'b0, 1'b0, 1'b0);

    bus.ovf_in = 1'b1;
    waitEdges(1);  // E61
    bus.ovf_in = 1'b0;
    checkOutput("lz_dp", lz_glyph, 3'b100, 1'b1, 1'b0, 1'b1);

    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset", GLYPH_BLANK, 3'b000, 1'b0, 1'b0, 1'b0);
    waitEdges(1);
    reset = 1'b0;
    waitEdges(1);
    checkOutput("after_reset", GLYPH_BLANK, 3'b000, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
